instruction_fetch: RTL
======================

# instruction_fetch

Program sequencer feeding the control unit's 10-bit `iiiidddddd` instruction word. It holds the program counter and reads the instruction memory over a request/valid interface. It issues each word to the control unit over a valid/ready handshake and resolves control flow itself: JMP, RST and illegal opcodes. It sits between the instruction memory and the decoder and is the only source of the `instruction` bus.

## Interface

Parameters:
- `ADDR_WIDTH`, default 8: program counter and memory address width.
- `PROG_LEN`, default 256: number of program words. The PC wraps to 0 after `PROG_LEN-1`. Must satisfy ≤ 2^ADDR_WIDTH.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  **asynchronous, active-high**; clears all state immediately.
- `run`  in  1  level; enables fetching.
- `mem_req`  out  1  one-cycle read strobe to instruction memory.
- `mem_addr`  out  ADDR_WIDTH  read address; always equals `pc`.
- `mem_valid`  in  1  memory data valid; only sampled in WAIT.
- `mem_data`  in  10  instruction word from memory.
- `instruction`  out  10  word issued to the control unit.
- `instr_valid`  out  1  `instruction` holds an issuable word.
- `instr_ready`  in  1  control unit accepts the word. Held low to stall, e.g. during LOAD/STORE.
- `pc`  out  ADDR_WIDTH  address of the word being fetched or issued.
- `halted`  out  1  FSM is in HALT.
- `fault`  out  1  sticky illegal-opcode flag.

## Operation

- States: IDLE, REQ, WAIT, ISSUE, HALT.
- Reset values: state IDLE, `pc`=0, `instruction`=0, and `instr_valid`, `mem_req`, `halted`, `fault` all 0.
- IDLE: if `run`=1, go to REQ.
- REQ: `mem_req`=1 for exactly this cycle, then go to WAIT.
- WAIT: wait indefinitely for `mem_valid`. When it is high, capture `mem_data` and decode opcode `mem_data[9:6]`:
  - opcode 0000–1100: load `instruction`, go to ISSUE.
  - opcode 1101–1111: set `fault`=1 and go to HALT. The word is never issued and `instruction` is unchanged.
- ISSUE: `instr_valid`=1. `instruction` stays stable until transfer, i.e. a cycle with `instr_valid` and `instr_ready` both high. `instr_valid` is never withdrawn before transfer. On transfer, update `pc`:
  - JMP (1001): `pc` ← zero-extended `instruction[5:0]`. If that value is ≥ `PROG_LEN`, use it modulo `PROG_LEN`.
  - RST (0111): `pc` ← 0. The word is still issued so the control unit raises its reset.
  - All other opcodes: `pc` ← `pc`+1, wrapping from `PROG_LEN-1` to 0.
  - Next state after transfer: REQ if `run`=1, otherwise IDLE.
- Dropping `run` in REQ, WAIT or ISSUE does not abort. The current word completes and the FSM then parks in IDLE.
- HALT: absorbing state with `halted`=1. Only `reset` exits it. `run` and `mem_valid` are ignored.
- A `mem_valid` outside WAIT is ignored. This covers a late response arriving after reset.

## Timing

- All outputs are registered except `mem_addr`, which is wired to `pc`.
- Minimum 3 cycles per instruction: REQ, then WAIT with `mem_valid` in its first cycle, then ISSUE with `instr_ready`=1.
- `mem_valid` may arrive no earlier than the cycle after `mem_req`.
- `instr_valid` rises on the edge that leaves WAIT and falls on the edge that completes the transfer.
- The `pc` update is visible the cycle after transfer, together with entry to REQ.
- Asynchronous reset in any state, including mid-WAIT or mid-ISSUE, immediately forces all reset values. The pending word is discarded without being issued.

## Test plan

- **Sequential fetch:** reset, then `run`=1. Memory returns 0000_001010 at addr 0 and 0001_011001 at addr 1, one cycle after each req, with `instr_ready`=1. Expect issue at cycles 3 and 6 after leaving IDLE, then `pc`=2.
- **Stall:** hold `instr_ready`=0 for 5 cycles in ISSUE. `instr_valid` and `instruction` must stay stable, with no new `mem_req`. Raise `instr_ready`: exactly one transfer occurs, then `pc`+1.
- **JMP and wrap:** set `PROG_LEN`=16. Word at addr 3 is 1001_000111: next fetch is addr 7. Word 1001_010100 (target 20): next fetch is addr 4. Sequential fetch from addr 15: next is addr 0.
- **RST:** word 0111_000000 at addr 5. It is issued with `instr_valid`=1, then the next `mem_addr`=0.
- **Illegal opcode:** word 1110_000000. Expect `fault`=1 and `halted`=1, `instr_valid` never asserted, and further `run`/`mem_valid` activity ignored. After `reset`, `fault`=0 and `halted`=0.
- **Reset mid-operation:** assert `reset` in WAIT, then release it with `run`=0. A `mem_valid` arriving one cycle later is ignored. Outputs show reset values and state is IDLE.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Program sequencer. Fetches 10-bit iiiidddddd words from
//               instruction memory and issues them to the control unit.
//               Resolves JMP, RST and illegal opcodes locally.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int PROG_LEN   = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [9:0]            mem_data,
    output logic [9:0]            instruction,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [3:0]            c_OP_RST        = 4'b0111;
    localparam logic [3:0]            c_OP_JMP        = 4'b1001;
    localparam logic [3:0]            c_OP_LAST_LEGAL = 4'b1100;
    localparam logic [ADDR_WIDTH-1:0] c_PC_LAST       = ADDR_WIDTH'(PROG_LEN - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [9:0]            r_instr;
    logic [9:0]            w_instr_nxt;
    logic                  r_fault;
    logic                  w_fault_nxt;
    logic                  r_mem_req;
    logic                  r_instr_valid;
    logic                  r_halted;

    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [ADDR_WIDTH-1:0] w_jmp_tgt;
    logic                  w_transfer;

    assign w_pc_inc   = (r_pc == c_PC_LAST) ? '0 : r_pc + ADDR_WIDTH'(1);
    // Jump targets beyond the program length fold back into it.
    assign w_jmp_tgt  = ADDR_WIDTH'({26'd0, r_instr[5:0]} % 32'(PROG_LEN));
    assign w_transfer = (r_state == S_ISSUE) && instr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_fault_nxt = r_fault;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_valid) begin
                    if (mem_data[9:6] <= c_OP_LAST_LEGAL) begin
                        w_instr_nxt = mem_data;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = S_HALT;
                    end
                end
            end
            S_ISSUE: begin
                if (w_transfer) begin
                    case (r_instr[9:6])
                        c_OP_JMP: w_pc_nxt = w_jmp_tgt;
                        c_OP_RST: w_pc_nxt = '0;
                        default:  w_pc_nxt = w_pc_inc;
                    endcase
                    w_state_nxt = run ? S_REQ : S_IDLE;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_fault       <= 1'b0;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_fault       <= w_fault_nxt;
            r_mem_req     <= (w_state_nxt == S_REQ);
            r_instr_valid <= (w_state_nxt == S_ISSUE);
            r_halted      <= (w_state_nxt == S_HALT);
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign fault       = r_fault;

endmodule
`default_nettype wire
